uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters. It sits between the requester logic (command responders, status reporters, debug taps) and the `uart_tx` byte input. It locks the grant for a whole packet so that bytes from different requesters never interleave on the line.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `MAX_PKT`, default 16: maximum bytes per grant; legal range 1..255.
- `ID_BASE`, default 8'hA0: header byte base, used only with `UART_ARB_ID_HDR_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on its data lane.
- `req_data`  in  8*NUM_REQ  flattened data; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  the current byte of requester i is its packet's final byte.
- `req_ready`  out  NUM_REQ  a byte of requester i is accepted this cycle.
- `tx_valid`  out  1  byte offered to `uart_tx`.
- `tx_data`  out  8  byte to transmit.
- `tx_ready`  in  1  `uart_tx` accepts the byte this cycle.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  a packet is in progress.
- `pkt_trunc`  out  1  one-cycle pulse when a grant is ended by `MAX_PKT` rather than `req_last`.

## Operation
- States: `S_IDLE`, `S_HDR` (present only with the macro), `S_XFER`.
- **Byte handshake:** a byte transfers on any cycle where `tx_valid && tx_ready`.
- **`S_IDLE`:**
  - `tx_valid`=0, `req_ready`=0, `grant`=0, `busy`=0.
  - If any `req_valid` bit is set, select the winner: the first set bit searching upward from the priority pointer `ptr`, wrapping modulo `NUM_REQ`.
  - Register the winner into `grant`, clear the byte counter, and go to `S_XFER`.
- **`S_XFER`** (g = granted index):
  - `tx_valid = req_valid[g]`, `tx_data = req_data[g]`, `req_ready[g] = tx_ready`; all other `req_ready` bits are 0.
  - Each transfer increments the byte counter. The counter is `$clog2(MAX_PKT+1)` bits wide and never wraps.
  - **Release:** on a transfer with `req_last[g]`=1, or on the transfer that brings the counter to `MAX_PKT`:
    - go to `S_IDLE`;
    - set `ptr` to (g+1) mod `NUM_REQ`;
    - clear `grant`.
  - **Truncation:** if the release is caused by the `MAX_PKT` limit and `req_last[g]`=0, pulse `pkt_trunc` in the following cycle. The requester's remaining bytes then compete as a new packet.
  - **Stall:** if `req_valid[g]` drops mid-packet, the grant is held indefinitely with `tx_valid`=0. There is no timeout.
- **Idle drive:** `tx_data` is 8'h00 whenever `tx_valid`=0.
- **Simultaneous events:** new `req_valid` bits asserted during `S_XFER` are ignored until `S_IDLE`. A request arriving in the release cycle is arbitrated in the next `S_IDLE` cycle using the updated `ptr`.
- **Reset:** forces `S_IDLE`, `ptr`=0, counter=0. Any packet in progress is abandoned. A byte already accepted by `uart_tx` is not recalled.

## Timing
- **Reset values:** `req_ready`=0, `tx_valid`=0, `tx_data`=8'h00, `grant`=0, `busy`=0, `pkt_trunc`=0.
- **Grant latency:**
  - `req_valid` is seen in `S_IDLE` at cycle N; `grant` and `busy` are high at cycle N+1.
  - The earliest first-byte transfer is cycle N+1, or N+2 with the header.
- **Datapath:** `tx_valid`, `tx_data` and `req_ready` are combinational from registered state plus `req_valid`, `req_data` and `tx_ready`. There is no combinational path from `tx_ready` to `tx_valid`.
- **Packet gap:** exactly one `S_IDLE` bubble cycle separates consecutive packets.
- **Back-pressure:** while `tx_valid`=1 and `tx_ready`=0, `tx_data` stays stable, provided the requester holds its lane (the requester contract).

## Configuration
- Macro `UART_ARB_ID_HDR_EN`.
- **Defined:**
  - `S_IDLE` goes to `S_HDR` instead of `S_XFER`.
  - `S_HDR` drives `tx_valid`=1 and `tx_data = ID_BASE | g` (g in the low 4 bits), with all `req_ready`=0.
  - On `tx_ready`, `S_HDR` goes to `S_XFER`. The header byte does not count toward `MAX_PKT`.
- **Undefined:** there is no `S_HDR`, no header byte is sent, and `ID_BASE` is unused.

## Test plan
- **Single packet:** requester 0 sends 8'h11, 8'h22, 8'h33 (`last` on 8'h33) with `tx_ready`=1 -> `grant`=4'b0001 one cycle after `req_valid`, `tx_data` shows 11, 22, 33 on consecutive cycles, `busy` falls after 33, next arbitration starts at requester 1.
- **Rotation:** all 4 requesters hold 1-byte packets 8'hA1..8'hA4 -> grant order 0,1,2,3,0, one idle cycle between grants, never two grant bits set.
- **Back-pressure:** `tx_ready` held low for 5 cycles during byte 2 of a requester 2 packet -> `req_ready[2]`=0, `tx_data` stable for 5 cycles, no byte lost or duplicated.
- **Truncation:** `MAX_PKT`=4, requester 1 sends 6 bytes without `last`, requester 3 pending -> `pkt_trunc` pulses once after byte 4, requester 3 granted next, then requester 1's remaining 2 bytes.
- **Reset mid-packet:** `reset` asserted during byte 2 of a requester 3 packet -> next cycle `grant`=0, `tx_valid`=0, `busy`=0; after release with requesters 2 and 0 pending, requester 0 wins.
- **Header (macro defined):** requester 2 sends 8'h55 with `last` -> `uart_tx` receives 8'hA2 then 8'h55, and `req_ready[2]` stays 0 during the header.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among NUM_REQ byte streams
//   clk, reset (sync, active-high); req_valid/req_data/req_last in, req_ready out per requester;
//   tx_valid/tx_data out, tx_ready in toward uart_tx; grant (one-hot owner), busy, pkt_trunc (1-cycle pulse) out.
//   Optional macro UART_ARB_ID_HDR_EN prepends a header byte ID_BASE|g to every packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_PKT = 16,
  parameter logic [7:0] ID_BASE = 8'hA0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 pkt_trunc
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT + 1);
`ifdef UART_ARB_ID_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;
  localparam state_t S_FIRST = S_HDR;
`else
  typedef enum logic {S_IDLE, S_XFER} state_t;
  localparam state_t S_FIRST = S_XFER;
  logic unused_id;
  assign unused_id = ^ID_BASE;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic trunc_q, trunc_d, found, xfer;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid[IW'((int'(ptr_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    trunc_d   = 1'b0;
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    xfer      = 1'b0;
    busy      = state_q != S_IDLE;
    grant     = busy ? NUM_REQ'(1) << g_q : '0;
    if (state_q == S_IDLE) begin
      if (found) begin
        g_d     = win;
        cnt_d   = '0;
        state_d = S_FIRST;
      end
`ifdef UART_ARB_ID_HDR_EN
    end else if (state_q == S_HDR) begin
      tx_valid = 1'b1;
      tx_data  = ID_BASE | 8'(g_q);
      state_d  = tx_ready ? S_XFER : S_HDR;
`endif
    end else begin
      tx_valid       = req_valid[g_q];
      tx_data        = tx_valid ? req_data[g_q*8 +: 8] : 8'h00;
      req_ready[g_q] = tx_ready;
      xfer           = tx_valid && tx_ready;
      if (xfer) cnt_d = cnt_q + CW'(1);
      // release on packet end or when this byte reaches the per-grant limit
      if (xfer && (req_last[g_q] || cnt_q == CW'(MAX_PKT - 1))) begin
        state_d = S_IDLE;
        ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
        trunc_d = !req_last[g_q];
      end
    end
  end
  assign pkt_trunc = trunc_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_PKT=4)
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [3:0]  grant;
  logic        busy;
  logic        pkt_trunc;
  int vecs = 0;
  int errs = 0;
  logic [7:0] sent[$];

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT(4), .ID_BASE(8'hA0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
    .pkt_trunc(pkt_trunc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_valid && tx_ready) sent.push_back(tx_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sent(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, sent.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent.size(); i++) chk(tag, sent[i], exp[i]);
    sent.delete();
  endtask

  initial begin
    tick;
    tick;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", pkt_trunc, 0);
    reset = 1'b0;
    sent.delete();
    // single packet from requester 0
    tx_ready = 1'b1;
    req_valid = 4'b0001; req_data[7:0] = 8'h11;
    #1;
    chk("sp_idle_grant", grant, 4'b0000);
    chk("sp_idle_txv", tx_valid, 0);
    tick;
    chk("sp_grant", grant, 4'b0001);
    chk("sp_busy", busy, 1);
    chk("sp_b1", tx_data, 8'h11);
    chk("sp_ready", req_ready, 4'b0001);
    tick;
    req_data[7:0] = 8'h22;
    #1;
    chk("sp_b2", tx_data, 8'h22);
    tick;
    req_data[7:0] = 8'h33; req_last = 4'b0001;
    #1;
    chk("sp_b3", tx_data, 8'h33);
    tick;
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    chk("sp_busy_fall", busy, 0);
    chk("sp_grant_fall", grant, 4'b0000);
    chk("sp_idle_data", tx_data, 8'h00);
    // pointer now at 1: requesters 0 and 3 pending, 3 must win
    req_valid = 4'b1001; req_last = 4'b1000; req_data[31:24] = 8'h44;
    tick;
    chk("ptr_grant", grant, 4'b1000);
    chk("ptr_data", tx_data, 8'h44);
    tick;
    req_valid = 4'b0000;
    chk_sent("sp_sent", '{8'h11, 8'h22, 8'h33, 8'h44});
    // rotation with all four holding 1-byte packets, pointer back at 0
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'hA4A3A2A1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rot_idle_grant", grant, 4'b0000);
      chk("rot_idle_busy", busy, 0);
      tick;
      chk("rot_grant", grant, 4'b0001 << (i % 4));
      chk("rot_data", tx_data, 8'hA1 + 8'(i % 4));
      tick;
    end
    chk_sent("rot_sent", '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA1});
    // back-pressure on requester 2, pointer at 1
    req_valid = 4'b0100; req_last = 4'b0000; req_data[23:16] = 8'hB1;
    tick;
    chk("bp_grant", grant, 4'b0100);
    chk("bp_b1", tx_data, 8'hB1);
    tick;
    req_data[23:16] = 8'hB2; tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", tx_valid, 1);
      chk("bp_hold_data", tx_data, 8'hB2);
      chk("bp_hold_ready", req_ready, 4'b0000);
      tick;
    end
    tx_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b0100);
    tick;
    req_data[23:16] = 8'hB3; req_last = 4'b0100;
    #1;
    chk("bp_b3", tx_data, 8'hB3);
    tick;
    req_valid = 4'b0000; req_last = 4'b0000;
    chk_sent("bp_sent", '{8'hB1, 8'hB2, 8'hB3});
    // truncation: requester 1 sends 6 bytes, requester 3 joins after the grant; pointer at 3
    req_valid = 4'b0010; req_data[15:8] = 8'hC1;
    tick;
    chk("tr_grant1", grant, 4'b0010);
    req_valid = 4'b1010; req_data[31:24] = 8'hD1; req_last = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      req_data[15:8] = 8'hC1 + 8'(i);
      #1;
      chk("tr_hold_grant", grant, 4'b0010);
      chk("tr_data", tx_data, 8'hC1 + 8'(i));
      chk("tr_no_pulse", pkt_trunc, 0);
      tick;
    end
    req_data[15:8] = 8'hC5;
    #1;
    chk("tr_pulse", pkt_trunc, 1);
    chk("tr_idle", grant, 4'b0000);
    tick;
    chk("tr_pulse_once", pkt_trunc, 0);
    chk("tr_grant3", grant, 4'b1000);
    chk("tr_d1", tx_data, 8'hD1);
    tick;
    req_valid = 4'b0010; req_last = 4'b0000;
    #1;
    chk("tr_last_no_pulse", pkt_trunc, 0);
    tick;
    chk("tr_grant1_again", grant, 4'b0010);
    chk("tr_c5", tx_data, 8'hC5);
    tick;
    req_data[15:8] = 8'hC6; req_last = 4'b0010;
    #1;
    chk("tr_c6", tx_data, 8'hC6);
    tick;
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    chk("tr_end_busy", busy, 0);
    chk("tr_end_trunc", pkt_trunc, 0);
    chk_sent("tr_sent", '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hC5, 8'hC6});
    // reset mid-packet on requester 3, pointer at 2
    req_valid = 4'b1000; req_data[31:24] = 8'hE1;
    tick;
    chk("rs_grant", grant, 4'b1000);
    tick;
    req_data[31:24] = 8'hE2; reset = 1'b1;
    #1;
    chk("rs_b2", tx_data, 8'hE2);
    tick;
    chk("rs_grant0", grant, 4'b0000);
    chk("rs_txv0", tx_valid, 0);
    chk("rs_busy0", busy, 0);
    chk("rs_ready0", req_ready, 4'b0000);
    reset = 1'b0;
    req_valid = 4'b0101; req_last = 4'b0101; req_data[7:0] = 8'hF0; req_data[23:16] = 8'hF2;
    #1;
    chk("rs_idle", grant, 4'b0000);
    chk_sent("rs_sent", '{8'hE1, 8'hE2});
    tick;
    chk("rs_winner", grant, 4'b0001);
    chk("rs_f0", tx_data, 8'hF0);
    tick;
    req_valid = 4'b0000;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
